// File: rtl/seg7_bcd_conv.sv
// Purpose: sequential binary-to-BCD converter (double-dabble, one bit per clock) with hex pass-through and overflow flag.
// Latency: exactly IN_W cycles from the accept edge to the o_done pulse, in every mode.
// Backpressure: o_ready is low while converting; i_valid without o_ready is dropped, never queued.
module seg7_bcd_conv #(
  parameter int IN_W = 27
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_valid,
  input  logic [IN_W-1:0] i_bin,
  input  logic            i_hex,
  output logic            o_ready,
  output logic            o_done,
  output logic [31:0]     o_data,
  output logic            o_ovf
);

  localparam int CW = $clog2(IN_W + 1);
  localparam logic [31:0] DEC_MAX = 32'd99_999_999;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state, state_nxt;
  logic [IN_W-1:0] bin_sr, bin_nxt;
  logic [IN_W-1:0] hold_bin;
  logic            hold_hex;
  logic            ovf_q;
  logic [31:0]     bcd, bcd_adj, bcd_nxt;
  logic [CW-1:0]   cnt;
  logic            accept, last;
  logic            ovf_in;
  logic [31:0]     bin_ext;

  // Per-digit add-3 correction, then shift {bcd, bin} left by one.
  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < 8; k++) begin
      if (bcd[4*k +: 4] >= 4'd5)
        bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
    bcd_nxt = {bcd_adj[30:0], bin_sr[IN_W-1]};
    bin_nxt = bin_sr << 1;
  end

  // Overflow is judged on the raw request at full width; narrow inputs never trip it.
  assign bin_ext = 32'(i_bin);
  assign ovf_in  = !i_hex && (bin_ext > DEC_MAX);

  // Next-state logic and handshake decode.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = 1'b0;
    o_ready   = (state == IDLE);
    case (state)
      IDLE: begin
        if (i_valid) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CW'(1)) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register, datapath and held result; reset wins over any in-flight conversion.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bin_sr   <= '0;
      bcd      <= '0;
      hold_bin <= '0;
      hold_hex <= 1'b0;
      ovf_q    <= 1'b0;
      cnt      <= '0;
      o_done   <= 1'b0;
      o_data   <= 32'h0000_0000;
      o_ovf    <= 1'b0;
    end else begin
      state  <= state_nxt;
      o_done <= last;
      if (accept) begin
        bin_sr   <= i_bin;
        bcd      <= '0;
        hold_bin <= i_bin;
        hold_hex <= i_hex;
        ovf_q    <= ovf_in;
        cnt      <= CW'(IN_W);
      end else if (state == SHIFT) begin
        bin_sr <= bin_nxt;
        bcd    <= bcd_nxt;
        cnt    <= cnt - CW'(1);
        if (last) begin
          if (ovf_q)
            o_data <= 32'hEEEE_EEEE;
          else if (hold_hex)
            o_data <= 32'(hold_bin);
          else
            o_data <= bcd_nxt;
          o_ovf <= ovf_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_bcd_conv.sv
// Purpose: randomized scoreboard bench for seg7_bcd_conv against a decimal-arithmetic reference.
// Latency: expects o_done exactly 27 cycles after each accept edge.
// Backpressure: stimulus waits for o_ready; requests during busy periods must be ignored.
module tb_seg7_bcd_conv;

  localparam int IN_W = 27;
  localparam int LAT  = 27;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_valid;
  logic [IN_W-1:0] i_bin;
  logic            i_hex;
  logic            o_ready;
  logic            o_done;
  logic [31:0]     o_data;
  logic            o_ovf;

  typedef struct {
    logic [31:0] data;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  seg7_bcd_conv #(.IN_W(IN_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .i_valid(i_valid),
    .i_bin  (i_bin),
    .i_hex  (i_hex),
    .o_ready(o_ready),
    .o_done (o_done),
    .o_data (o_data),
    .o_ovf  (o_ovf)
  );

  always #5 clk = ~clk;

  // Count rising edges so latency can be measured in cycles.
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: decimal digits by repeated division, overflow / hex rules applied on top.
  function automatic exp_t ref_model(input logic [IN_W-1:0] b, input logic hex, input int acc);
    exp_t e;
    longint unsigned v;
    v = longint'(b);
    e.acc = acc;
    e.ovf = (!hex && v > 64'd99_999_999);
    e.data = 32'h0;
    if (e.ovf) begin
      e.data = 32'hEEEE_EEEE;
    end else if (hex) begin
      e.data = 32'(b);
    end else begin
      for (int k = 0; k < 8; k++) begin
        e.data = e.data | (32'(v % 10) << (4 * k));
        v = v / 10;
      end
    end
    return e;
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: every o_done pops one expectation and checks data, flag and latency.
  always @(negedge clk) begin
    if (o_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: o_done=1 at cycle %0d, expected none", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("o_data", longint'(o_data), longint'(e.data));
        check("o_ovf", longint'(o_ovf), longint'(e.ovf));
        check("latency", longint'(cyc - e.acc), longint'(LAT));
      end
    end
  end

  // Issue one request when the DUT is ready; returns the accept cycle.
  task automatic issue(input logic [IN_W-1:0] b, input logic hex, output int acc);
    int n;
    n = 0;
    while (!o_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!o_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout: o_ready=0 after %0d cycles, expected 1", n);
    end
    i_valid = 1'b1;
    i_bin   = b;
    i_hex   = hex;
    acc     = cyc + 1;
    exp_q.push_back(ref_model(b, hex, acc));
    @(negedge clk);
    i_valid = 1'b0;
    check("ready_drop", longint'(o_ready), 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int a1, a2;
    rst = 1'b1; i_valid = 1'b0; i_bin = '0; i_hex = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", longint'(o_ready), 1);
    check("rst_done", longint'(o_done), 0);
    check("rst_data", longint'(o_data), 0);
    check("rst_ovf", longint'(o_ovf), 0);

    // Directed cases: zero, back-to-back, overflow then recovery, hex max.
    issue(27'd0, 1'b0, a1); drain();
    issue(27'd12_345_678, 1'b0, a1);
    issue(27'd99_999_999, 1'b0, a2);
    check("b2b_accept", longint'(a2 - a1), longint'(LAT + 1));
    drain();
    issue(27'd100_000_000, 1'b0, a1); drain();
    issue(27'd7, 1'b0, a1); drain();
    issue(27'h7FF_FFFF, 1'b1, a1); drain();

    // Requests while busy must be ignored.
    issue(27'd42, 1'b0, a1);
    repeat (3) @(negedge clk);
    i_valid = 1'b1; i_bin = 27'd99;
    repeat (6) @(negedge clk);
    i_valid = 1'b0;
    drain();
    repeat (5) @(negedge clk);
    check("no_second_conv", longint'(o_ready), 1);

    // Reset mid-conversion abandons the result.
    issue(27'd555, 1'b0, a1);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("midrst_ready", longint'(o_ready), 1);
    check("midrst_data", longint'(o_data), 0);
    check("midrst_ovf", longint'(o_ovf), 0);
    repeat (40) @(negedge clk);

    // Randomized mix of decimal, hex and overflow values.
    for (int i = 0; i < 30; i++) begin
      logic [IN_W-1:0] b;
      logic h;
      b = IN_W'($urandom);
      if ($urandom_range(0, 1) == 0) b = IN_W'($urandom_range(0, 99_999_999));
      h = ($urandom_range(0, 3) == 0);
      issue(b, h, a1);
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    drain();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_bcd_conv.md
Name: seg7_bcd_conv

Overview:
- Sequential binary-to-BCD converter. It sits directly upstream of the 8-digit seg7x16 scanning display driver and produces the 32-bit packed-nibble word on that driver's i_data input.
- Converts an unsigned binary value to 8 BCD digits using iterative double-dabble (shift-and-add-3), one bit per clock.
- Also offers a hex pass-through mode and an overflow indication.
- Result is held stable between conversions, so the display never shows a partial value.

Parameters:
- IN_W, 27, width of i_bin in bits. Legal range 1..32; 27 is the minimum width that covers 99,999,999.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- i_valid  input  1  request a conversion of i_bin.
- i_bin  input  IN_W  unsigned value to convert.
- i_hex  input  1  1 = hex pass-through, 0 = decimal conversion.
- o_ready  output  1  converter idle; a request will be accepted this cycle.
- o_done  output  1  one-cycle pulse; o_data/o_ovf updated this cycle.
- o_data  output  32  8 packed nibbles, digit 0 in [3:0], digit 7 in [31:28]; feeds the display driver's i_data.
- o_ovf  output  1  last decimal request exceeded 99,999,999.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, o_ready=1, o_done=0, o_data=32'h0000_0000, o_ovf=0, iteration counter=0, internal shift registers cleared.
- Reset has priority over every other event, including a mid-conversion cycle. An active conversion is abandoned with no o_done pulse.
- States: IDLE, SHIFT.
- o_ready = (state==IDLE), combinational from state only.
- Accept edge T0 = a rising edge with state IDLE and i_valid=1. On T0:
  - Capture i_bin into a binary shift register.
  - Clear the 32-bit BCD accumulator.
  - Capture i_hex and i_bin into holding registers.
  - Compute the overflow flag: i_hex==0 and i_bin > 99,999,999. Evaluate at full IN_W width; for IN_W<27 the flag is always 0.
  - Set counter=IN_W; state -> SHIFT.
- SHIFT, each edge:
  - For each of the 8 BCD nibbles with value >=5, add 3 to that nibble (4-bit add, no carry between nibbles).
  - Then shift {BCD, binary} left by 1: binary MSB enters BCD bit 0; BCD bit 31 is discarded.
  - Decrement counter.
- Edge where counter goes 1->0 (edge T_IN_W):
  - state -> IDLE; o_done=1 for exactly this one cycle.
  - o_data loads from the post-shift result, with priority:
    - ovf=1 -> 32'hEEEE_EEEE;
    - hex=1 -> zero-extended captured i_bin;
    - else the final BCD accumulator.
  - o_ovf loads the captured ovf flag.
- Latency is exactly IN_W cycles from accept edge to the edge that raises o_done, regardless of mode and overflow.
- Because o_ready is high in the o_done cycle, a new request may be accepted on the next edge (throughput: one result per IN_W+1 cycles).
- i_valid while o_ready=0 is ignored: no queueing, no error flag. i_bin/i_hex changes during SHIFT have no effect.
- o_data and o_ovf hold their values from o_done until the next o_done or reset. o_done is 0 at all other times.
- IN_W=32 decimal mode: values above 99,999,999 are flagged as overflow by the comparison. Discarded BCD carry-out never reaches o_data, because the overflow pattern overrides it.

Test Plan:
1. Reset, then i_valid=1, i_bin=0, i_hex=0 for one cycle.
   -> o_ready drops next cycle; o_done pulses exactly 27 cycles after the accept edge; o_data=32'h0000_0000, o_ovf=0.
2. i_bin=12,345,678 decimal, then i_bin=99,999,999 back-to-back, second request issued in the o_done cycle.
   -> o_data=32'h1234_5678, then 32'h9999_9999 27 cycles after the second accept; second request accepted on the edge following the first o_done.
3. i_bin=100,000,000, i_hex=0.
   -> o_data=32'hEEEE_EEEE, o_ovf=1.
   Follow with i_bin=7, i_hex=0.
   -> o_data=32'h0000_0007, o_ovf=0.
4. i_bin=27'h7FF_FFFF, i_hex=1.
   -> o_data=32'h07FF_FFFF, o_ovf=0, same 27-cycle latency.
5. Accept i_bin=42, then assert i_valid with i_bin=99 on cycles 5..10 of SHIFT.
   -> single o_done; o_data=32'h0000_0042; no second conversion starts.
6. Accept i_bin=555, assert rst for one cycle at SHIFT cycle 10, then hold i_valid=0.
   -> o_ready=1 the cycle after reset; o_data=0, o_ovf=0; no o_done pulse ever appears.
